// File: rtl/dl_reader_if.sv
// dl_reader_if: bus-side bundle between the DL databus / ALU control and the
// DL->DV receive buffer.
//   DL      8  internal databus, true polarity, idles at 8'hFF
//   DataIn  1  load strobe: capture DL at this edge
//   Pop     1  ALU consumed the head entry
//   Flush   1  discard all entries, clear Overrun
//   DV      8  head entry for ALU Operand2 (8'hFF when empty)
//   DVValid 1  head entry present
//   Full    1  both entries occupied
//   Overrun 1  sticky: a load was dropped while full
// master = bus/ALU control side, slave = the buffer itself.
interface dl_reader_if;
  logic [7:0] DL;
  logic       DataIn;
  logic       Pop;
  logic       Flush;
  logic [7:0] DV;
  logic       DVValid;
  logic       Full;
  logic       Overrun;

  modport master (output DL, DataIn, Pop, Flush,
                  input  DV, DVValid, Full, Overrun);
  modport slave  (input  DL, DataIn, Pop, Flush,
                  output DV, DVValid, Full, Overrun);
endinterface

// File: rtl/dl_reader.sv
// dl_reader: 2-entry receive buffer from the DL databus to the ALU Operand2
// path. Loads are captured on DataIn, the head entry is presented on DV and
// retired on Pop. Every output is decoded from registers only.
//   CLK2    1  sole clock, rising edge
//   nRESET  1  synchronous active-low reset
//   bus     dl_reader_if.slave (DL/DataIn/Pop/Flush in, DV/DVValid/Full/Overrun out)
module dl_reader (
  input  logic        CLK2,
  input  logic        nRESET,
  dl_reader_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [7:0] head_q, head_d;
  logic [7:0] tail_q, tail_d;
  logic       ovr_q, ovr_d;

  always_ff @(posedge CLK2) begin
    if (!nRESET) begin
      state_q <= EMPTY;
      head_q  <= 8'hFF;
      tail_q  <= 8'hFF;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovr_d   = ovr_q;
    if (bus.Flush) begin
      // Flush overrides any load/pop in the same cycle.
      state_d = EMPTY;
      head_d  = 8'hFF;
      tail_d  = 8'hFF;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          // Pop on empty is silently ignored.
          if (bus.DataIn) begin
            head_d  = bus.DL;
            state_d = ONE;
          end
        end
        ONE: begin
          if (bus.DataIn && bus.Pop) begin
            head_d = bus.DL;
          end else if (bus.DataIn) begin
            tail_d  = bus.DL;
            state_d = TWO;
          end else if (bus.Pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (bus.Pop) begin
            // Tail advances to head; a same-cycle load refills the tail.
            head_d = tail_q;
            if (bus.DataIn) tail_d = bus.DL;
            else            state_d = ONE;
          end else if (bus.DataIn) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign bus.DVValid = (state_q != EMPTY);
  assign bus.Full    = (state_q == TWO);
  assign bus.Overrun = ovr_q;
  // Empty buffer looks like the precharged idle bus.
  assign bus.DV      = bus.DVValid ? head_q : 8'hFF;
endmodule

// File: tb/tb_dl_reader.sv
// tb_dl_reader: directed + short random stimulus for dl_reader with a queue
// scoreboard of accepted bytes and a sticky overrun model.
module tb_dl_reader;
  logic CLK2;
  logic nRESET;
  dl_reader_if bus ();

  dl_reader dut (.CLK2(CLK2), .nRESET(nRESET), .bus(bus));

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic       m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check outputs.
  task automatic step(input logic din, input logic [7:0] dl, input logic pop,
                      input logic fl, input logic rn);
    int n;
    logic popped;
    bus.DataIn = din; bus.DL = dl; bus.Pop = pop; bus.Flush = fl; nRESET = rn;
    if (rn && !fl && pop && sb.size() > 0) chk("pop_head", bus.DV, sb[0]);
    @(posedge CLK2);
    #1;
    if (!rn || fl) begin
      sb.delete();
      m_ovr = 1'b0;
    end else begin
      popped = pop && (sb.size() > 0);
      if (popped) void'(sb.pop_front());
      if (din) begin
        if (sb.size() < 2) sb.push_back(dl);
        else               m_ovr = 1'b1;
      end
    end
    n = sb.size();
    chk("dv",      bus.DV,      (n > 0) ? sb[0] : 8'hFF);
    chk("dvvalid", {7'd0, bus.DVValid}, {7'd0, n > 0});
    chk("full",    {7'd0, bus.Full},    {7'd0, n == 2});
    chk("overrun", {7'd0, bus.Overrun}, {7'd0, m_ovr});
  endtask

  initial begin
    bus.DataIn = 1'b0; bus.DL = 8'hFF; bus.Pop = 1'b0; bus.Flush = 1'b0;
    nRESET = 1'b0;
    @(negedge CLK2);

    // Reset with a load strobe active: nothing captured.
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("rst_dv", bus.DV, 8'hFF);
    chk("rst_ovr", {7'd0, bus.Overrun}, 8'h00);

    // Single load / pop.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("load_a5", bus.DV, 8'hA5);
    step(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);  // DL ignored without DataIn
    chk("dl_ignored", bus.DV, 8'hA5);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("pop_empty_dv", bus.DV, 8'hFF);

    // Fill and order, then extra pop on empty.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("fill_full", {7'd0, bus.Full}, 8'h01);
    chk("fill_head", bus.DV, 8'h11);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("order_22", bus.DV, 8'h22);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("underflow_ovr", {7'd0, bus.Overrun}, 8'h00);

    // Overrun: third load dropped, flag sticky through pops.
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
    chk("ovr_set", {7'd0, bus.Overrun}, 8'h01);
    chk("ovr_head", bus.DV, 8'h01);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("ovr_pop1", bus.DV, 8'h02);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("ovr_drained", bus.DV, 8'hFF);
    chk("ovr_sticky", {7'd0, bus.Overrun}, 8'h01);
    step(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    chk("ovr_flushed", {7'd0, bus.Overrun}, 8'h00);

    // Simultaneous load+pop while full.
    step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h30, 1'b1, 1'b0, 1'b1);
    chk("sim_head", bus.DV, 8'h20);
    chk("sim_full", {7'd0, bus.Full}, 8'h01);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("sim_30", bus.DV, 8'h30);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);

    // Flush mid-operation beats a same-cycle load.
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    chk("flush_dv", bus.DV, 8'hFF);
    chk("flush_valid", {7'd0, bus.DVValid}, 8'h00);

    // Same again with reset instead of flush.
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_dv", bus.DV, 8'hFF);
    chk("rst_mid_ovr", {7'd0, bus.Overrun}, 8'h00);

    // Sustained one load+pop per cycle starting from ONE.
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b1);
    chk("stream_ovr", {7'd0, bus.Overrun}, 8'h00);
    chk("stream_head", bus.DV, 8'hC8);

    // Random mix.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dl_reader.md
# dl_reader

Receive-side counterpart of the DV→DL bridge: captures the internal databus DL into a 2-entry buffer and presents the head entry on DV to the ALU operand path under a valid/pop handshake. Decouples bus read cycles from ALU consumption so two back-to-back bus loads are not lost while the ALU is busy. Sits between the DL bus and the ALU Operand2 input, alongside the existing DV→DL driver.

## Interface
- No parameters; data width fixed at 8 bits.
- CLK2  input  1  Sole clock; all state updates on its rising edge.
- nRESET  input  1  Reset; synchronous and active-low.
- DL  input  8  Internal databus, true polarity; precharged to 8'hFF when idle.
- DataIn  input  1  Load strobe: capture DL at this edge (DL→DV direction).
- Pop  input  1  ALU consumed the current head entry.
- Flush  input  1  Discard all buffered entries and clear Overrun.
- DV  output  8  Head entry for ALU Operand2; 8'hFF when buffer empty.
- DVValid  output  1  Head entry present.
- Full  output  1  Both entries occupied.
- Overrun  output  1  Sticky: a load was dropped because the buffer was full.

## Operation
- States by occupancy: EMPTY (0), ONE (1), TWO (2). Two data registers, head and tail, plus state register.
- Priority per edge: nRESET low > Flush > Pop/DataIn.
- nRESET low: state EMPTY, DV=8'hFF, DVValid=0, Full=0, Overrun=0; data registers set to 8'hFF. Applies mid-operation; any edge with nRESET low discards everything.
- Flush: state EMPTY, Overrun=0, DV=8'hFF. A DataIn or Pop in the same cycle is ignored.
- EMPTY: DataIn → ONE, head=DL. Pop ignored (no underflow, no flag).
- ONE: DataIn only → TWO, tail=DL. Pop only → EMPTY. DataIn+Pop → ONE, head=DL.
- TWO: Pop only → ONE, head=tail. DataIn+Pop → TWO, head=tail, tail=DL. DataIn only → stays TWO, DL discarded, Overrun=1.
- Overrun stays 1 until Flush or reset; Pop alone never clears it.
- DV = head when DVValid=1, otherwise forced 8'hFF (matches idle bus).
- Full = (state==TWO); DVValid = (state!=EMPTY). All outputs registered or decoded from registers only; no combinational path from DL, DataIn, or Pop to any output.
- No data modification: captured byte is stored bit-exact.

## Timing
- Capture latency: DataIn high at edge N with EMPTY → DV=DL(N), DVValid=1 from just after edge N.
- Pop at edge N → next entry (or 8'hFF/DVValid=0) visible just after edge N.
- Sustained throughput: one DataIn+Pop per cycle with no stall and no Overrun when starting from ONE.
- DL is sampled only at edges where DataIn=1; DL value at other edges has no effect.
- Reset takes effect at the first rising CLK2 edge with nRESET=0; outputs at reset values after that edge.

## Test plan
- Reset: hold nRESET=0 one edge with DataIn=1, DL=8'h3C → DV=8'hFF, DVValid=0, Full=0, Overrun=0.
- Single load/pop: DataIn with DL=8'hA5 → next cycle DV=8'hA5, DVValid=1; Pop → DV=8'hFF, DVValid=0.
- Fill and order: load 8'h11 then 8'h22 → Full=1, DV=8'h11; Pop → DV=8'h22, Full=0; Pop → EMPTY; extra Pop leaves EMPTY, no flags.
- Overrun: load 8'h01, 8'h02, 8'h03 with no Pop → Overrun=1, DV=8'h01; Pops yield 8'h01, 8'h02 only; Overrun remains 1 until Flush.
- Simultaneous: in TWO holding 8'h10/8'h20, DataIn+Pop with DL=8'h30 → DV=8'h20, Full=1, Overrun=0; then Pops yield 8'h20, 8'h30.
- Flush/reset mid-operation: in TWO with Overrun=1, Flush+DataIn (DL=8'h55) → EMPTY, DV=8'hFF, Overrun=0, 8'h55 not stored; repeat with nRESET=0 instead of Flush → same result.
